// File: rtl/leaf_user_fifo.sv
// Elastic vld/ack buffer with a registered first-word-fall-through head,
// registered handshakes and an occupancy count.
module leaf_user_fifo #(
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH_BITS   = 4,
  parameter int AF_LEVEL     = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    din_vld,
  output logic                    din_ack,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    dout_vld,
  input  logic                    dout_ack,
  output logic [DEPTH_BITS:0]     count,
  output logic                    almost_full
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   FULL_CNT = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]   AF_CNT   = (DEPTH_BITS+1)'(AF_LEVEL);
  localparam logic [DEPTH_BITS:0]   ONE_CNT  = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] ONE_PTR  = DEPTH_BITS'(1);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr_next;
  logic [DEPTH_BITS:0]     count_next;
  logic                    push;
  logic                    pop;
  logic                    head_load;
  logic [PAYLOAD_BITS-1:0] head_next;

  assign push        = din_vld && din_ack;
  assign pop         = dout_vld && dout_ack;
  assign rd_ptr_next = rd_ptr + ONE_PTR;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + ONE_CNT;
    else if (!push && pop)
      count_next = count - ONE_CNT;
  end

  // The head slot is also a storage slot: every word is written to mem, and
  // dout is a registered copy of mem[rd_ptr]. When the successor has not yet
  // been written (empty, or one word held), it is taken straight from din.
  always_comb begin
    head_load = 1'b0;
    head_next = din;
    if (!dout_vld) begin
      head_load = push;
    end else if (pop) begin
      if (count == ONE_CNT) begin
        head_load = push;
      end else begin
        head_load = 1'b1;
        head_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      din_ack     <= 1'b0;
      almost_full <= 1'b0;
      dout_vld    <= 1'b0;
      dout        <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)
        rd_ptr <= rd_ptr_next;
      count       <= count_next;
      din_ack     <= (count_next != FULL_CNT);
      almost_full <= (count_next >= AF_CNT);
      dout_vld    <= (count_next != '0);
      if (head_load)
        dout <= head_next;
    end
  end

endmodule

// File: tb/tb_leaf_user_fifo.sv
// Randomized and directed checks of leaf_user_fifo against a queue model.
module tb_leaf_user_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] din = '0;
  logic        din_vld = 1'b0;
  logic        din_ack;
  logic [31:0] dout;
  logic        dout_vld;
  logic        dout_ack = 1'b0;
  logic [4:0]  count;
  logic        almost_full;

  int tests = 0;
  int fails = 0;

  // Reference model: ordered word queue plus "first edge after reset seen".
  logic [31:0] q[$];
  bit          ack_live = 1'b0;

  always #5 clk = ~clk;

  leaf_user_fifo #(
    .PAYLOAD_BITS(32),
    .DEPTH_BITS  (4),
    .AF_LEVEL    (12)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_vld    (din_vld),
    .din_ack    (din_ack),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .dout_ack   (dout_ack),
    .count      (count),
    .almost_full(almost_full)
  );

  function automatic bit exp_ack();
    return ack_live && (q.size() != 16);
  endfunction

  // Drive one cycle of inputs at the falling edge; model transfers at the
  // rising edge; return 1 ns after the rising edge.
  task automatic drive_cycle(input bit vld, input logic [31:0] data, input bit ack,
                             output bit pushed, output bit popped);
    @(negedge clk);
    din      = data;
    din_vld  = vld;
    dout_ack = ack;
    pushed   = vld && exp_ack();
    popped   = ack && (q.size() != 0);
    @(posedge clk);
    if (popped) void'(q.pop_front());
    if (pushed) q.push_back(data);
    ack_live = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    din_vld  = 1'b0;
    dout_ack = 1'b0;
    reset_n  = 1'b0;
    q.delete();
    ack_live = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (din_ack !== 1'b0 || dout_vld !== 1'b0 || dout !== 32'h0 || count !== 5'd0 || almost_full !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: ack=%b vld=%b dout=%h count=%0d af=%b, want all 0",
               din_ack, dout_vld, dout, count, almost_full);
    end
    reset_n = 1'b1;
    #1;
    tests++;
    if (din_ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_ack: got %b want 0 before first edge", din_ack);
    end
    @(posedge clk);
    ack_live = 1'b1;
    #1;
    tests++;
    if (din_ack !== 1'b1 || count !== 5'd0) begin
      fails++;
      $display("FAIL reset_first_edge: ack=%b count=%0d want ack=1 count=0", din_ack, count);
    end
  endtask

  task automatic test_fill();
    bit p, o;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 32'(i), 1'b0, p, o);
      tests++;
      if (count !== 5'(q.size()) || count !== 5'(i + 1)) begin
        fails++;
        $display("FAIL fill_count: word %0d got %0d want %0d", i, count, i + 1);
      end
      tests++;
      if (almost_full !== (i + 1 >= 12)) begin
        fails++;
        $display("FAIL fill_af: word %0d got %b want %b", i, almost_full, (i + 1 >= 12));
      end
      tests++;
      if (din_ack !== exp_ack()) begin
        fails++;
        $display("FAIL fill_ack: word %0d got %b want %b", i, din_ack, exp_ack());
      end
      tests++;
      if (dout_vld !== 1'b1 || dout !== 32'h0) begin
        fails++;
        $display("FAIL fill_head: word %0d got vld=%b dout=%h want vld=1 dout=0", i, dout_vld, dout);
      end
    end
    drive_cycle(1'b1, 32'h10, 1'b0, p, o);
    tests++;
    if (count !== 5'd16 || din_ack !== 1'b0 || p) begin
      fails++;
      $display("FAIL fill_hold: count=%0d ack=%b want count=16 ack=0", count, din_ack);
    end
  endtask

  task automatic test_drain();
    bit p, o;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (dout_vld !== 1'b1 || dout !== 32'(i)) begin
        fails++;
        $display("FAIL drain_order: slot %0d got vld=%b dout=%h want vld=1 dout=%h", i, dout_vld, dout, 32'(i));
      end
      drive_cycle(1'b0, 32'h0, 1'b1, p, o);
      tests++;
      if (din_ack !== 1'b1 || count !== 5'(15 - i)) begin
        fails++;
        $display("FAIL drain_state: slot %0d ack=%b count=%0d want ack=1 count=%0d", i, din_ack, count, 15 - i);
      end
    end
    tests++;
    if (dout_vld !== 1'b0 || almost_full !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: vld=%b af=%b want 0 0", dout_vld, almost_full);
    end
  endtask

  task automatic test_stream_wrap();
    bit p, o;
    logic [31:0] d_before;
    logic        v_before;
    int          nout = 0;
    for (int i = 0; i < 40; i++) begin
      d_before = dout;
      v_before = dout_vld;
      drive_cycle(1'b1, 32'h100 + 32'(i), 1'b1, p, o);
      tests++;
      if (v_before !== (i > 0)) begin
        fails++;
        $display("FAIL stream_gap: cycle %0d vld=%b want %b", i, v_before, (i > 0));
      end
      if (v_before === 1'b1) begin
        tests++;
        if (d_before !== 32'h100 + 32'(nout)) begin
          fails++;
          $display("FAIL stream_data: word %0d got %h want %h", nout, d_before, 32'h100 + 32'(nout));
        end
        nout++;
      end
      tests++;
      if (count !== 5'd1 || din_ack !== 1'b1) begin
        fails++;
        $display("FAIL stream_count: cycle %0d count=%0d ack=%b want 1 1", i, count, din_ack);
      end
    end
    tests++;
    if (dout !== 32'h100 + 32'd39 || dout_vld !== 1'b1) begin
      fails++;
      $display("FAIL stream_last: got vld=%b dout=%h want 1 %h", dout_vld, dout, 32'h100 + 32'd39);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, p, o);
  endtask

  task automatic test_backpressure();
    bit p, o, ack, held;
    logic [31:0] prev;
    int pushes = 0;
    int pops = 0;
    for (int c = 0; c < 3000 && (pushes < 200 || q.size() != 0); c++) begin
      ack  = ($urandom_range(1, 0) == 1);
      held = dout_vld && !ack;
      prev = dout;
      drive_cycle((pushes < 200) && ($urandom_range(3, 0) != 0), $urandom, ack, p, o);
      pushes += int'(p);
      pops   += int'(o);
      if (held) begin
        tests++;
        if (dout !== prev || dout_vld !== 1'b1) begin
          fails++;
          $display("FAIL bp_stable: cycle %0d got vld=%b dout=%h want 1 %h", c, dout_vld, dout, prev);
        end
      end
      tests++;
      if (count !== 5'(pushes - pops) || dout_vld !== (q.size() != 0) || din_ack !== exp_ack()) begin
        fails++;
        $display("FAIL bp_state: cycle %0d count=%0d vld=%b ack=%b want %0d %b %b",
                 c, count, dout_vld, din_ack, pushes - pops, (q.size() != 0), exp_ack());
      end
      if (q.size() != 0) begin
        tests++;
        if (dout !== q[0]) begin
          fails++;
          $display("FAIL bp_data: cycle %0d got %h want %h", c, dout, q[0]);
        end
      end
    end
    tests++;
    if (pushes != 200 || pops != 200) begin
      fails++;
      $display("FAIL bp_budget: pushes=%0d pops=%0d want 200 200", pushes, pops);
    end
  endtask

  task automatic test_reset_mid();
    bit p, o;
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, 32'hC000 + 32'(i), 1'b0, p, o);
    tests++;
    if (count !== 5'd7) begin
      fails++;
      $display("FAIL rmid_prefill: count=%0d want 7", count);
    end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if (dout_vld !== 1'b0 || count !== 5'd0 || din_ack !== 1'b0 || dout !== 32'h0) begin
      fails++;
      $display("FAIL rmid_async_clear: vld=%b count=%0d ack=%b dout=%h want 0 0 0 0", dout_vld, count, din_ack, dout);
    end
    #1 reset_n = 1'b1;
    q.delete();
    ack_live = 1'b0;
    drive_cycle(1'b1, 32'hDEADBEEF, 1'b1, p, o);
    tests++;
    if (din_ack !== 1'b1 || count !== 5'd0 || dout_vld !== 1'b0) begin
      fails++;
      $display("FAIL rmid_release: ack=%b count=%0d vld=%b want 1 0 0", din_ack, count, dout_vld);
    end
    drive_cycle(1'b1, 32'hA5A5A5A5, 1'b0, p, o);
    tests++;
    if (dout !== 32'hA5A5A5A5 || dout_vld !== 1'b1 || count !== 5'd1) begin
      fails++;
      $display("FAIL rmid_first_word: dout=%h vld=%b count=%0d want a5a5a5a5 1 1", dout, dout_vld, count);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, p, o);
  endtask

  task automatic test_bypass();
    bit p, o;
    drive_cycle(1'b1, 32'h11, 1'b0, p, o);
    tests++;
    if (dout !== 32'h11 || dout_vld !== 1'b1 || count !== 5'd1) begin
      fails++;
      $display("FAIL bypass_first: dout=%h vld=%b count=%0d want 11 1 1", dout, dout_vld, count);
    end
    drive_cycle(1'b1, 32'h22, 1'b1, p, o);
    tests++;
    if (dout !== 32'h22 || dout_vld !== 1'b1 || count !== 5'd1) begin
      fails++;
      $display("FAIL bypass_swap: dout=%h vld=%b count=%0d want 22 1 1", dout, dout_vld, count);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, p, o);
    tests++;
    if (dout_vld !== 1'b0 || count !== 5'd0) begin
      fails++;
      $display("FAIL bypass_drain: vld=%b count=%0d want 0 0", dout_vld, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream_wrap();
    test_backpressure();
    test_reset_mid();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
